tdm_demux_rx: RTL
=================

Name: tdm_demux_rx

Overview:
- Receive end of the 4-channel nibble link: a four-slot time-division-multiplexed stream carries one word per channel per frame, slot 0 first.
- Locks onto frame boundaries using a start-of-frame marker.
- Routes each slot into one of four registered channel outputs W/X/Y/Z, with per-channel update strobes.
- Detects framing loss (misplaced marker, missing marker, stalled frame) and counts errors.
- Sits between the link input and the per-channel consumers; it is the sequential counterpart of the 4:1 channel multiplexer on the transmit side.

Parameters:
- DATA_W, 4, width of each slot word and each channel output.
- TIMEOUT, 15, number of consecutive idle cycles inside a partial frame before lock is dropped (range 1..255).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  block enable; low = ignore link, drop lock.
- in_valid  input  1  in_data/in_sof valid this cycle.
- in_sof  input  1  marks the slot-0 beat of a frame; only meaningful with in_valid.
- in_data  input  DATA_W  slot word.
- W  output  DATA_W  channel 0 (slot 0) registered output.
- X  output  DATA_W  channel 1 (slot 1) registered output.
- Y  output  DATA_W  channel 2 (slot 2) registered output.
- Z  output  DATA_W  channel 3 (slot 3) registered output.
- upd  output  4  one-cycle strobe, bit n set when channel n output was written this cycle.
- frame_done  output  1  one-cycle pulse when slot 3 of a frame is written.
- locked  output  1  high while in RECV state.
- frame_err  output  1  one-cycle pulse on any framing error.
- err_count  output  8  saturating framing-error count.

Behaviour:
- Reset (rst_n low, async): state=HUNT, slot=0, idle counter=0; W,X,Y,Z=0; upd=0; frame_done=0; frame_err=0; locked=0; err_count=0.
- Output latency: a beat sampled on edge k appears on its channel output, together with its upd bit, after edge k. Strobe outputs are registered. Unwritten channels hold their value.
- State HUNT:
  - in_valid&in_sof: write W, upd[0]=1, slot=1, go to RECV.
  - in_valid without in_sof: beat discarded, no error.
- State RECV, in_valid beat:
  - in_sof with slot==0: normal frame start; write W, slot=1.
  - in_sof with slot!=0: early marker. Raise frame_err and increment err_count. Resync by treating the beat as slot 0: write W, slot=1. Partial-frame channels keep what was already written; no frame_done.
  - No in_sof, slot in 1..3: write the channel selected by slot (1→X, 2→Y, 3→Z) and set the matching upd bit.
    - slot 3 additionally pulses frame_done and sets slot=0.
    - Otherwise slot increments.
  - No in_sof, slot==0: missing marker. Raise frame_err, increment err_count, discard the beat, go to HUNT.
- Idle counter:
  - Counts RECV cycles with in_valid low while slot!=0; any in_valid beat clears it.
  - Reaching TIMEOUT: raise frame_err, increment err_count, go to HUNT, set slot=0, clear the counter.
  - It does not count while slot==0 (between frames); idle links are legal there.
- enable low (sampled each cycle):
  - Beats ignored; state forced to HUNT, slot=0, idle counter=0.
  - W/X/Y/Z hold; upd, frame_done and frame_err held 0; err_count holds.
  - On re-enable, the block needs a fresh in_sof.
- err_count saturates at 255 and never wraps.
- Simultaneous events: if a beat arrives on the same cycle the timeout would fire, the beat wins and the counter clears. Only one error is counted per cycle.
- locked reflects the registered state: it rises the cycle after the first accepted in_sof and falls the cycle after any return to HUNT.
- Reset mid-frame: all outputs return to reset values immediately; partial frame lost.

Test Plan:
- Clean frame: sof+0x1, 0x2, 0x3, 0x4 on consecutive cycles → W=1,X=2,Y=3,Z=4; upd=0001,0010,0100,1000 on successive cycles; frame_done one pulse with Z=4; locked=1; err_count=0.
- Gapped frame: same beats with 3 idle cycles between each (TIMEOUT=15) → identical outputs, no frame_err; then 16 idle cycles after slot 1 → frame_err pulse, locked=0, err_count=1, Z unchanged.
- Early marker: sof+0xA, 0xB, sof+0xC, 0xD, 0xE, 0xF → frame_err on the third beat, err_count=1; final W=C, X=D, Y=E, Z=F; exactly one frame_done.
- Missing marker: full frame 1..4, then non-sof 0x9 → frame_err, err_count=1, locked drops, W stays 1; a later sof+0x5 relocks and W=5.
- Enable/reset: enable low mid-frame → outputs hold, locked=0, beats ignored. Re-enable with non-sof beats → nothing written. Assert rst_n low asynchronously mid-frame → all outputs 0 before the next clk edge.
- Saturation: force 260 missing-marker errors → err_count stops at 255.

Source files
------------

// File: rtl/tdm_demux_rx.sv
// Receive side of the 4-channel nibble link: frame-locks on in_sof, demultiplexes
// the four TDM slots onto registered W/X/Y/Z outputs and counts framing errors.
module tdm_demux_rx #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] W,
    output logic [DATA_W-1:0] X,
    output logic [DATA_W-1:0] Y,
    output logic [DATA_W-1:0] Z,
    output logic [3:0]        upd,
    output logic              frame_done,
    output logic              locked,
    output logic              frame_err,
    output logic [7:0]        err_count
);

    typedef enum logic {HUNT, RECV} state_t;

    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

    state_t            state, state_n;
    logic [1:0]        slot, slot_n;
    logic [7:0]        idle, idle_n;
    logic [DATA_W-1:0] w_n, x_n, y_n, z_n;
    logic [3:0]        upd_n;
    logic              fd_n;
    logic              err;
    logic [7:0]        err_count_n;

    always_comb begin
        state_n = state;
        slot_n  = slot;
        idle_n  = idle;
        w_n     = W;
        x_n     = X;
        y_n     = Y;
        z_n     = Z;
        upd_n   = '0;
        fd_n    = 1'b0;
        err     = 1'b0;

        if (!enable) begin
            state_n = HUNT;
            slot_n  = '0;
            idle_n  = '0;
        end else begin
            unique case (state)
                HUNT: begin
                    if (in_valid && in_sof) begin
                        w_n     = in_data;
                        upd_n   = 4'b0001;
                        slot_n  = 2'd1;
                        idle_n  = '0;
                        state_n = RECV;
                    end
                end
                RECV: begin
                    if (in_valid) begin
                        idle_n = '0;
                        if (in_sof) begin
                            // A marker off slot 0 resyncs: this beat becomes slot 0.
                            err    = (slot != 2'd0);
                            w_n    = in_data;
                            upd_n  = 4'b0001;
                            slot_n = 2'd1;
                        end else if (slot == 2'd0) begin
                            err     = 1'b1;
                            state_n = HUNT;
                        end else begin
                            unique case (slot)
                                2'd1:    x_n = in_data;
                                2'd2:    y_n = in_data;
                                default: z_n = in_data;
                            endcase
                            upd_n[slot] = 1'b1;
                            fd_n        = (slot == 2'd3);
                            slot_n      = slot + 2'd1;
                        end
                    end else if (slot != 2'd0) begin
                        if (idle == IDLE_LAST) begin
                            err     = 1'b1;
                            state_n = HUNT;
                            slot_n  = '0;
                            idle_n  = '0;
                        end else begin
                            idle_n = idle + 8'd1;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end

        err_count_n = err_count;
        if (err && err_count != 8'hFF)
            err_count_n = err_count + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            slot       <= '0;
            idle       <= '0;
            W          <= '0;
            X          <= '0;
            Y          <= '0;
            Z          <= '0;
            upd        <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_n;
            slot       <= slot_n;
            idle       <= idle_n;
            W          <= w_n;
            X          <= x_n;
            Y          <= y_n;
            Z          <= z_n;
            upd        <= upd_n;
            frame_done <= fd_n;
            frame_err  <= err;
            err_count  <= err_count_n;
        end
    end

    assign locked = (state == RECV);

endmodule
